// File: rtl/digit_scan_ctrl_pkg.sv
// digit_scan_ctrl_pkg: shared state encoding, glyph table and register-map constants
package digit_scan_ctrl_pkg;
    typedef enum logic [1:0] {LOAD, SCAN, DEAD, OFF} state_t;
    localparam int DEF_ON_CYC = 20000;
    localparam int DEF_DEAD_CYC = 16;
    localparam logic [31:0] DIGIT_REG_ADDR = 32'h0000_0010;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    // Active-low {g,f,e,d,c,b,a} per hex value, one byte per entry, F at the top
    localparam logic [127:0] GLYPH_TBL = 128'h0E06_2146_0308_1000_7802_1219_3024_7940;
    function automatic logic [3:0] find_next(input logic [7:0] m, input logic [3:0] from);
        find_next = 4'd0;
        for (int i = 7; i >= 0; i--)
            if (m[i] && i >= int'(from)) find_next = {1'b1, 3'(i)};
    endfunction
endpackage

// File: rtl/digit_scan_ctrl_seg7_decode.sv
// seg7_decode: hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}
module seg7_decode
    import digit_scan_ctrl_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    assign seg = GLYPH_TBL[{hex, 3'b000} +: 7];
endmodule

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: time-multiplexed 8-digit hex display scanner with blanking and
// leading-zero suppression; every output is a flop so digit select and segments switch together.
module digit_scan_ctrl
    import digit_scan_ctrl_pkg::*;
#(
    parameter int ON_CYC = DEF_ON_CYC,
    parameter int DEAD_CYC = DEF_DEAD_CYC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic        data_vld,
    input  logic [7:0]  en_mask,
    input  logic        lz_en,
    output logic [7:0]  led_en,
    output logic        led_ca,
    output logic        led_cb,
    output logic        led_cc,
    output logic        led_cd,
    output logic        led_ce,
    output logic        led_cf,
    output logic        led_cg,
    output logic        led_dp
);
    localparam int MAXC = ON_CYC > DEAD_CYC ? ON_CYC : DEAD_CYC;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] ON_LD = CW'(ON_CYC - 1);
    localparam logic [CW-1:0] DEAD_LD = CW'(DEAD_CYC - 1);
    state_t state;
    logic [CW-1:0] cnt;
    logic [2:0] idx;
    logic [31:0] pending, shadow, cur_data;
    logic [7:0] mask_q;
    logic lz_q, cur_lz;
    logic [3:0] first, nxt;
    logic [2:0] tgt;
    logic [6:0] dec, seg_n, seg_q;
    // Decode the digit about to be entered; in LOAD it comes straight from the incoming frame
    assign cur_data = state == LOAD ? (data_vld ? data : pending) : shadow;
    assign cur_lz = state == LOAD ? lz_en : lz_q;
    assign first = find_next(en_mask, 4'd0);
    assign nxt = find_next(mask_q, {1'b0, idx} + 4'd1);
    assign tgt = state == LOAD ? first[2:0] : nxt[2:0];
    seg7_decode u_dec (.hex(cur_data[{tgt, 2'b00} +: 4]), .seg(dec));
    assign seg_n = cur_lz && tgt != 3'd0 && (cur_data >> {tgt, 2'b00}) == 32'd0 ? SEG_BLANK : dec;
    assign {led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca} = seg_q;
    assign led_dp = 1'b1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
            cnt <= '0;
            idx <= 3'd0;
            pending <= 32'd0;
            shadow <= 32'd0;
            mask_q <= 8'd0;
            lz_q <= 1'b0;
            led_en <= 8'hFF;
            seg_q <= SEG_BLANK;
        end else begin
            if (data_vld) pending <= data;
            case (state)
                LOAD: begin
                    shadow <= cur_data;
                    mask_q <= en_mask;
                    lz_q <= lz_en;
                    state <= first[3] ? SCAN : OFF;
                    if (first[3]) begin
                        idx <= first[2:0];
                        cnt <= ON_LD;
                        led_en <= ~(8'd1 << first[2:0]);
                        seg_q <= seg_n;
                    end
                end
                SCAN: begin
                    cnt <= cnt == '0 ? DEAD_LD : cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= DEAD;
                        led_en <= 8'hFF;
                        seg_q <= SEG_BLANK;
                    end
                end
                DEAD: begin
                    cnt <= cnt == '0 ? (nxt[3] ? ON_LD : '0) : cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= nxt[3] ? SCAN : LOAD;
                        if (nxt[3]) begin
                            idx <= nxt[2:0];
                            led_en <= ~(8'd1 << nxt[2:0]);
                            seg_q <= seg_n;
                        end
                    end
                end
                default: if (en_mask != 8'd0) state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl: scoreboard bench; expected slots are queued when stimulus is driven and
// compared against slots the monitor reconstructs from the display pins.
module tb_digit_scan_ctrl;
    localparam int ON = 4;
    localparam int DEAD = 2;
    typedef struct {logic [7:0] en; logic [6:0] seg; int len; int start;} slot_t;
    typedef struct {logic [7:0] en; logic [6:0] seg;} exp_t;
    logic clk = 0, rst = 1, data_vld = 0, lz_en = 0;
    logic [31:0] data = 0;
    logic [7:0] en_mask = 0, led_en;
    logic led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg, led_dp;
    logic [6:0] seg;
    int passed = 0, total = 0, rd = 0, cyc = 0, bad_cnt = 0, run = 0, start = 0;
    logic [7:0] prev = 8'hFF;
    logic [6:0] prev_seg = 7'h7F;
    slot_t obs_q[$];
    exp_t exp_q[$];

    digit_scan_ctrl #(.ON_CYC(ON), .DEAD_CYC(DEAD)) dut (
        .clk(clk), .rst(rst), .data(data), .data_vld(data_vld), .en_mask(en_mask), .lz_en(lz_en),
        .led_en(led_en), .led_ca(led_ca), .led_cb(led_cb), .led_cc(led_cc), .led_cd(led_cd),
        .led_ce(led_ce), .led_cf(led_cf), .led_cg(led_cg), .led_dp(led_dp)
    );
    assign seg = {led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if ($countones(~led_en) > 1 || led_dp !== 1'b1) bad_cnt <= bad_cnt + 1;
        if (led_en !== prev) begin
            if (prev !== 8'hFF) obs_q.push_back('{prev, prev_seg, run, start});
            start <= cyc;
            run <= 1;
        end else run <= run + 1;
        prev <= led_en;
        prev_seg <= seg;
    end

    function automatic logic [6:0] glyph(input logic [3:0] h);
        logic [6:0] on;
        case (h)
            4'h0: on = 7'h3F; 4'h1: on = 7'h06; 4'h2: on = 7'h5B; 4'h3: on = 7'h4F;
            4'h4: on = 7'h66; 4'h5: on = 7'h6D; 4'h6: on = 7'h7D; 4'h7: on = 7'h07;
            4'h8: on = 7'h7F; 4'h9: on = 7'h6F; 4'hA: on = 7'h77; 4'hB: on = 7'h7C;
            4'hC: on = 7'h39; 4'hD: on = 7'h5E; 4'hE: on = 7'h79; default: on = 7'h71;
        endcase
        return ~on;
    endfunction

    task automatic push_frame(input logic [31:0] d, input logic [7:0] m, input bit lz);
        for (int k = 0; k < 8; k++)
            if (m[k]) exp_q.push_back('{8'(~(8'd1 << k)),
                (lz && k > 0 && (d >> (4 * k)) == 32'd0) ? 7'h7F : glyph(d[4 * k +: 4])});
    endtask

    task automatic pop_slot(output slot_t s, output bit ok);
        int n = 0;
        while (rd >= obs_q.size() && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = rd < obs_q.size();
        s = ok ? obs_q[rd] : '{8'h00, 7'h00, 0, 0};
        if (ok) rd++;
    endtask

    task automatic do_reset(input logic [31:0] d, input logic [7:0] m, input bit lz, output int rel);
        @(negedge clk);
        rst = 1; data = d; en_mask = m; lz_en = lz; data_vld = 0;
        repeat (2) @(negedge clk);
        rd = obs_q.size();
        exp_q.delete();
        rst = 0; data_vld = 1; rel = cyc;
        @(negedge clk);
        data_vld = 0;
    endtask

    task automatic test_reset();
        slot_t s; exp_t e; bit ok; int st[16]; int rel;
        rst = 1; data = 32'h12345678; en_mask = 8'hFF; lz_en = 0;
        repeat (3) @(negedge clk);
        total++; if (led_en !== 8'hFF) $display("FAIL reset_led_en: got %h want ff", led_en); else passed++;
        total++; if (seg !== 7'h7F || led_dp !== 1'b1) $display("FAIL reset_seg: got seg=%h dp=%b want 7f/1", seg, led_dp); else passed++;
        rd = obs_q.size();
        rst = 0; data_vld = 1; rel = cyc;
        push_frame(32'h12345678, 8'hFF, 0);
        push_frame(32'h12345678, 8'hFF, 0);
        @(negedge clk);
        data_vld = 0;
        for (int i = 0; i < 16; i++) begin
            pop_slot(s, ok); e = exp_q.pop_front(); st[i] = s.start; total++;
            if (!ok || s.en !== e.en || s.seg !== e.seg || s.len !== ON)
                $display("FAIL reset_slot %0d: got en=%h seg=%h len=%0d want en=%h seg=%h len=%0d", i, s.en, s.seg, s.len, e.en, e.seg, ON);
            else passed++;
        end
        total++; if (st[0] !== rel + 1) $display("FAIL first_load: got start %0d want %0d", st[0], rel + 1); else passed++;
        total++; if (st[8] - st[0] !== 49) $display("FAIL frame_period_ff: got %0d want 49", st[8] - st[0]); else passed++;
    endtask

    task automatic test_sparse_mask();
        slot_t s; exp_t e; bit ok; int st[12]; int rel;
        do_reset(32'h12345678, 8'hFF, 0, rel);
        push_frame(32'h12345678, 8'hFF, 0);
        push_frame(32'h12345678, 8'h81, 0);
        push_frame(32'h12345678, 8'h81, 0);
        repeat (4) @(negedge clk);
        en_mask = 8'h81;
        for (int i = 0; i < 12; i++) begin
            pop_slot(s, ok); e = exp_q.pop_front(); st[i] = s.start; total++;
            if (!ok || s.en !== e.en || s.seg !== e.seg || s.len !== ON)
                $display("FAIL sparse_slot %0d: got en=%h seg=%h len=%0d want en=%h seg=%h len=%0d", i, s.en, s.seg, s.len, e.en, e.seg, ON);
            else passed++;
        end
        total++; if (st[8] - st[0] !== 49) $display("FAIL mask_deferred: got %0d want 49", st[8] - st[0]); else passed++;
        total++; if (st[10] - st[8] !== 13) $display("FAIL frame_period_81: got %0d want 13", st[10] - st[8]); else passed++;
    endtask

    task automatic test_mid_update(input logic [31:0] d0, input logic [31:0] d1, input bit lz, input logic [7:0] at_en);
        slot_t s; exp_t e; bit ok; int rel; int n = 0;
        do_reset(d0, 8'hFF, lz, rel);
        push_frame(d0, 8'hFF, lz);
        push_frame(d1, 8'hFF, lz);
        while (led_en !== at_en && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++; if (led_en !== at_en) $display("FAIL update_wait: got en=%h want %h", led_en, at_en); else passed++;
        data = d1; data_vld = 1;
        @(negedge clk);
        data_vld = 0;
        for (int i = 0; i < 16; i++) begin
            pop_slot(s, ok); e = exp_q.pop_front(); total++;
            if (!ok || s.en !== e.en || s.seg !== e.seg || s.len !== ON)
                $display("FAIL update_slot %h %0d: got en=%h seg=%h len=%0d want en=%h seg=%h len=%0d", d1, i, s.en, s.seg, s.len, e.en, e.seg, ON);
            else passed++;
        end
    endtask

    task automatic test_zero_mask();
        slot_t s; exp_t e; bit ok; int rel; int cx;
        do_reset(32'h12345678, 8'hFF, 0, rel);
        push_frame(32'h12345678, 8'hFF, 0);
        repeat (2) @(negedge clk);
        en_mask = 8'h00;
        for (int i = 0; i < 8; i++) begin
            pop_slot(s, ok); e = exp_q.pop_front(); total++;
            if (!ok || s.en !== e.en || s.seg !== e.seg || s.len !== ON)
                $display("FAIL zero_slot %0d: got en=%h seg=%h len=%0d want en=%h seg=%h len=%0d", i, s.en, s.seg, s.len, e.en, e.seg, ON);
            else passed++;
        end
        repeat (60) @(negedge clk);
        total++; if (obs_q.size() !== rd || led_en !== 8'hFF || seg !== 7'h7F)
            $display("FAIL off_state: got en=%h seg=%h extra=%0d want ff/7f/0", led_en, seg, obs_q.size() - rd);
        else passed++;
        en_mask = 8'h01; cx = cyc;
        push_frame(32'h12345678, 8'h01, 0);
        pop_slot(s, ok); e = exp_q.pop_front(); total++;
        if (!ok || s.en !== e.en || s.seg !== e.seg || s.len !== ON)
            $display("FAIL wake_slot: got en=%h seg=%h len=%0d want en=%h seg=%h len=%0d", s.en, s.seg, s.len, e.en, e.seg, ON);
        else passed++;
        total++; if (s.start !== cx + 2) $display("FAIL wake_latency: got start %0d want %0d", s.start, cx + 2); else passed++;
    endtask

    task automatic test_mid_reset();
        slot_t s; exp_t e; bit ok; int st[8]; int rel; int n = 0;
        do_reset(32'h12345678, 8'hFF, 0, rel);
        while (led_en !== 8'hFB && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++; if (led_en !== 8'hFB) $display("FAIL reset_wait: got en=%h want fb", led_en); else passed++;
        @(posedge clk);
        #2 rst = 1;
        #1;
        total++; if (led_en !== 8'hFF || seg !== 7'h7F) $display("FAIL async_reset: got en=%h seg=%h want ff/7f", led_en, seg); else passed++;
        repeat (2) @(negedge clk);
        rd = obs_q.size();
        data = 32'h9ABCDEF0; rst = 0; rel = cyc;
        push_frame(32'h0, 8'hFF, 0);
        for (int i = 0; i < 8; i++) begin
            pop_slot(s, ok); e = exp_q.pop_front(); st[i] = s.start; total++;
            if (!ok || s.en !== e.en || s.seg !== e.seg || s.len !== ON)
                $display("FAIL restart_slot %0d: got en=%h seg=%h len=%0d want en=%h seg=%h len=%0d", i, s.en, s.seg, s.len, e.en, e.seg, ON);
            else passed++;
        end
        total++; if (st[0] !== rel + 1) $display("FAIL restart_time: got start %0d want %0d", st[0], rel + 1); else passed++;
    endtask

    initial begin
        test_reset();
        test_sparse_mask();
        test_mid_update(32'h12345678, 32'hFFFFFFFF, 0, 8'hF7);
        test_mid_update(32'h76543210, 32'hFEDCBA98, 0, 8'hFD);
        test_mid_update(32'h00000A00, 32'h00000000, 1, 8'hFE);
        test_zero_mask();
        test_mid_reset();
        total++; if (bad_cnt !== 0) $display("FAIL pin_sanity: got %0d bad cycles want 0", bad_cnt); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
